sd_command_responder: RTL and testbench

- Downstream of the SPI command receiver; consumes its decoded command and argument.
- Tracks SD-card initialisation state: IDLE → READY, plus the CMD55 application-command prefix.
- Builds the SPI-mode response (R1, R3 or R7) and streams it byte-by-byte to the SPI transmit shifter over a valid/ready handshake.

---
 rtl/sd_pkg.sv | 39 +++
 rtl/sd_resp_buffer.sv | 79 +++++++
 rtl/sd_command_responder.sv | 162 ++++++++++++++++
 tb/tb_sd_command_responder.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sd_pkg: command indices, R1 bit layout, OCR window and responder FSM states. Rev 1.0
// ----------------------------------------------------------------------------
package sd_pkg;

    localparam logic [5:0] CMD0  = 6'd0;
    localparam logic [5:0] CMD8  = 6'd8;
    localparam logic [5:0] CMD16 = 6'd16;
    localparam logic [5:0] CMD41 = 6'd41;
    localparam logic [5:0] CMD55 = 6'd55;
    localparam logic [5:0] CMD58 = 6'd58;

    localparam int R1_IDLE    = 0;
    localparam int R1_ILLEGAL = 2;
    localparam int R1_CRC     = 3;
    localparam int R1_PARAM   = 6;

    localparam logic [23:0] OCR_VOLTAGE = 24'hFF_80_00;

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_DECODE = 2'd1,
        ST_SEND   = 2'd2
    } state_t;

    function automatic logic [7:0] make_r1(input logic idle, input logic illegal,
                                           input logic crc, input logic param);
        logic [7:0] r;
        r             = 8'h00;
        r[R1_IDLE]    = idle;
        r[R1_ILLEGAL] = illegal;
        r[R1_CRC]     = crc;
        r[R1_PARAM]   = param;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sd_resp_buffer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sd_resp_buffer: 5-byte response load/shift register with valid/ready output. Rev 1.0
// ----------------------------------------------------------------------------
module sd_resp_buffer (
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic        abort,
    input  logic [39:0] load_data,
    input  logic [2:0]  load_len,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    output logic        last_sent
);

    logic [39:0] data_q, data_d;
    logic [2:0]  len_q, len_d;
    logic [2:0]  idx_q, idx_d;
    logic        valid_q, valid_d;
    logic [7:0]  cur_byte;
    logic        xfer;

    // Byte 0 sits in the top lane so responses go out MSB first.
    always_comb begin
        case (idx_q)
            3'd0:    cur_byte = data_q[39:32];
            3'd1:    cur_byte = data_q[31:24];
            3'd2:    cur_byte = data_q[23:16];
            3'd3:    cur_byte = data_q[15:8];
            3'd4:    cur_byte = data_q[7:0];
            default: cur_byte = 8'hFF;
        endcase
    end

    assign xfer      = valid_q & tx_ready;
    assign last_sent = xfer & (idx_q == (len_q - 3'd1));

    always_comb begin
        data_d  = data_q;
        len_d   = len_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        if (abort) begin
            valid_d = 1'b0;
            idx_d   = 3'd0;
        end else if (load) begin
            data_d  = load_data;
            len_d   = load_len;
            idx_d   = 3'd0;
            valid_d = (load_len != 3'd0);
        end else if (last_sent) begin
            valid_d = 1'b0;
            idx_d   = 3'd0;
        end else if (xfer) begin
            idx_d = idx_q + 3'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data_q  <= 40'd0;
            len_q   <= 3'd0;
            idx_q   <= 3'd0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
        end
    end

    assign tx_data  = valid_q ? cur_byte : 8'hFF;
    assign tx_valid = valid_q;

endmodule
`default_nettype wire

// File: rtl/sd_command_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sd_command_responder: SD SPI-mode command decode, card state and response streamer. Rev 1.0
// ----------------------------------------------------------------------------
module sd_command_responder
    import sd_pkg::*;
#(
    parameter int   INIT_POLLS = 2,
    parameter logic CCS        = 1'b1,
    parameter int   BLOCK_LEN  = 512
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_ArgumentReadFinished,
    input  logic        io_ReadSuccess,
    input  logic [5:0]  io_Command,
    input  logic [31:0] io_CommandArgument,
    output logic [7:0]  io_TxData,
    output logic        io_TxValid,
    input  logic        io_TxReady,
    output logic        io_CardIdle,
    output logic        io_AppPending,
    output logic        io_Busy
);

    localparam logic [3:0]  POLLS_TGT   = 4'(INIT_POLLS);
    localparam logic [31:0] BLOCK_LEN_W = 32'(BLOCK_LEN);

    state_t      state_q, state_d;
    logic        arf_q;
    logic [5:0]  cmd_q, cmd_d;
    logic [31:0] arg_q, arg_d;
    logic        ok_q, ok_d;
    logic        ready_q, ready_d;
    logic        app_q, app_d;
    logic [3:0]  polls_q, polls_d;
    logic [3:0]  polls_inc;
    logic        trigger;
    logic        load, abort, last_sent;
    logic [39:0] load_data;
    logic [2:0]  load_len;
    logic        illegal, crc, param;
    logic [7:0]  r1;
    logic [31:0] ocr;

    assign trigger   = io_ArgumentReadFinished & ~arf_q;
    assign cmd_d     = trigger ? io_Command         : cmd_q;
    assign arg_d     = trigger ? io_CommandArgument : arg_q;
    assign ok_d      = trigger ? io_ReadSuccess     : ok_q;
    assign polls_inc = polls_q + 4'd1;

    always_comb begin
        state_d   = state_q;
        ready_d   = ready_q;
        app_d     = app_q;
        polls_d   = polls_q;
        load      = 1'b0;
        abort     = 1'b0;
        load_len  = 3'd1;
        load_data = 40'hFF_FFFF_FFFF;
        illegal   = 1'b0;
        crc       = 1'b0;
        param     = 1'b0;
        r1        = 8'h00;
        ocr       = 32'h0;
        case (state_q)
            ST_WAIT: begin
                if (trigger) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                load    = 1'b1;
                state_d = ST_SEND;
                app_d   = 1'b0;
                if (!ok_q) begin
                    crc = 1'b1;
                end else begin
                    case (cmd_q)
                        CMD0: begin
                            ready_d = 1'b0;
                            polls_d = 4'd0;
                        end
                        CMD55: app_d = 1'b1;
                        CMD41: begin
                            if (!app_q) begin
                                illegal = 1'b1;
                            end else if (!ready_q) begin
                                polls_d = polls_inc;
                                if (polls_inc == POLLS_TGT) ready_d = 1'b1;
                            end
                        end
                        CMD16:       param = (arg_q != BLOCK_LEN_W);
                        CMD8, CMD58: begin end
                        default:     illegal = 1'b1;
                    endcase
                end
                // The idle bit reports the state after this command has taken effect.
                r1  = make_r1(~ready_d, illegal, crc, param);
                ocr = {ready_d, CCS, 6'b0, OCR_VOLTAGE};
                if (ok_q && cmd_q == CMD8) begin
                    load_len  = 3'd5;
                    load_data = {r1, 16'h0000, 4'h0,
                                 (arg_q[11:8] == 4'h1) ? 4'h1 : 4'h0, arg_q[7:0]};
                end else if (ok_q && cmd_q == CMD58) begin
                    load_len  = 3'd5;
                    load_data = {r1, ocr};
                end else begin
                    load_data = {r1, 32'hFFFF_FFFF};
                end
            end
            ST_SEND: begin
                if (trigger) begin
                    abort   = 1'b1;
                    state_d = ST_DECODE;
                end else if (last_sent) begin
                    state_d = ST_WAIT;
                end
            end
            default: state_d = ST_WAIT;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_WAIT;
            arf_q   <= 1'b0;
            cmd_q   <= 6'd0;
            arg_q   <= 32'd0;
            ok_q    <= 1'b0;
            ready_q <= 1'b0;
            app_q   <= 1'b0;
            polls_q <= 4'd0;
        end else begin
            state_q <= state_d;
            arf_q   <= io_ArgumentReadFinished;
            cmd_q   <= cmd_d;
            arg_q   <= arg_d;
            ok_q    <= ok_d;
            ready_q <= ready_d;
            app_q   <= app_d;
            polls_q <= polls_d;
        end
    end

    sd_resp_buffer u_buf (
        .clock     (clock),
        .reset     (reset),
        .load      (load),
        .abort     (abort),
        .load_data (load_data),
        .load_len  (load_len),
        .tx_ready  (io_TxReady),
        .tx_data   (io_TxData),
        .tx_valid  (io_TxValid),
        .last_sent (last_sent)
    );

    assign io_CardIdle   = ~ready_q;
    assign io_AppPending = app_q;
    assign io_Busy       = (state_q != ST_WAIT);

endmodule
`default_nettype wire

// File: tb/tb_sd_command_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_sd_command_responder: randomized bench with a transaction-level card model. Rev 1.0
// ----------------------------------------------------------------------------
module tb_sd_command_responder;

    localparam int INIT_POLLS = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        arf   = 1'b0;
    logic        ok    = 1'b0;
    logic [5:0]  cmd   = 6'd0;
    logic [31:0] arg   = 32'd0;
    logic        tx_ready = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid, card_idle, app_pending, busy;

    sd_command_responder #(.INIT_POLLS(INIT_POLLS), .CCS(1'b1), .BLOCK_LEN(512)) dut (
        .clock                   (clock),
        .reset                   (reset),
        .io_ArgumentReadFinished (arf),
        .io_ReadSuccess          (ok),
        .io_Command              (cmd),
        .io_CommandArgument      (arg),
        .io_TxData               (tx_data),
        .io_TxValid              (tx_valid),
        .io_TxReady              (tx_ready),
        .io_CardIdle             (card_idle),
        .io_AppPending           (app_pending),
        .io_Busy                 (busy)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int rmode    = 0;   // 0 ready high, 1 toggle, 2 random, 3 held low, 4 driven by main

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Card model: state, scheduled response bytes and flags as seen on the pins.
    bit         m_ready = 0, m_app = 0;
    int         m_polls = 0;
    bit         v_idle = 1, v_app = 0;
    logic [7:0] q[$];
    logic [7:0] got[$];
    int         delay = 0;
    bit         arf_prev = 0;
    int         trig_cyc = 0, first_v_cyc = -1;

    task automatic model_reset();
        m_ready = 0; m_app = 0; m_polls = 0;
        v_idle = 1; v_app = 0;
        q.delete(); delay = 0; arf_prev = 0;
    endtask

    function automatic void decode(input logic [5:0] c, input logic [31:0] a, input bit good);
        bit illegal = 0, crc = 0, param = 0;
        bit app_was = m_app;
        logic [7:0] r1;
        q.delete();
        m_app = 0;
        if (!good) crc = 1;
        else case (c)
            6'd0:  begin m_ready = 0; m_polls = 0; end
            6'd55: m_app = 1;
            6'd41: begin
                if (!app_was) illegal = 1;
                else if (!m_ready) begin
                    m_polls++;
                    if (m_polls >= INIT_POLLS) m_ready = 1;
                end
            end
            6'd16: param = (a != 32'd512);
            6'd8, 6'd58: ;
            default: illegal = 1;
        endcase
        r1 = 8'((m_ready ? 0 : 1) + (illegal ? 4 : 0) + (crc ? 8 : 0) + (param ? 64 : 0));
        q.push_back(r1);
        if (good && c == 6'd8) begin
            q.push_back(8'h00); q.push_back(8'h00);
            q.push_back((a[11:8] == 4'h1) ? 8'h01 : 8'h00);
            q.push_back(a[7:0]);
        end else if (good && c == 6'd58) begin
            q.push_back(m_ready ? 8'hC0 : 8'h40);
            q.push_back(8'hFF); q.push_back(8'h80); q.push_back(8'h00);
        end
    endfunction

    // Single compare process: every cycle out of reset, outputs must match the model.
    always @(negedge clock) begin
        if (reset) begin
            bit         exp_valid;
            logic [7:0] exp_data;
            bit         trig;
            cyc++;
            exp_valid = (delay == 0) && (q.size() > 0);
            exp_data  = exp_valid ? q[0] : 8'hFF;
            chk("tx_valid", 32'(tx_valid), 32'(exp_valid));
            chk("tx_data", 32'(tx_data), 32'(exp_data));
            chk("busy", 32'(busy), 32'((delay == 1) || (q.size() > 0)));
            chk("card_idle", 32'(card_idle), 32'(v_idle));
            chk("app_pending", 32'(app_pending), 32'(v_app));
            if (tx_valid && first_v_cyc < 0) first_v_cyc = cyc;
            if (exp_valid && tx_ready) got.push_back(q.pop_front());
            trig = arf && !arf_prev;
            if (trig) begin
                decode(cmd, arg, ok);
                delay = 1; trig_cyc = cyc; first_v_cyc = -1;
            end else if (delay == 1) begin
                delay = 0; v_idle = !m_ready; v_app = m_app;
            end
            arf_prev = arf;
        end
    end

    initial begin
        forever begin
            @(posedge clock); #1;
            case (rmode)
                0: tx_ready = 1'b1;
                1: tx_ready = ~tx_ready;
                2: tx_ready = 1'($urandom_range(0, 1));
                3: tx_ready = 1'b0;
                default: ;
            endcase
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic issue(input logic [5:0] c, input logic [31:0] a, input bit good);
        @(posedge clock); #1;
        cmd = c; arg = a; ok = good; arf = 1'b1;
        @(posedge clock); #1;
        arf = 1'b0; cmd = 6'($urandom); arg = $urandom; ok = 1'($urandom);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy !== 1'b0 && k < 300) begin @(negedge clock); k++; end
        #1;
        if (k >= 300) chk("busy_timeout", 32'(busy), 32'd0);
    endtask

    task automatic expect_resp(input string name, input int n, input logic [39:0] b);
        chk({name, "_len"}, 32'(got.size()), 32'(n));
        for (int i = 0; i < n && i < got.size(); i++)
            chk(name, 32'(got[i]), 32'(b[39 - 8*i -: 8]));
        got.delete();
    endtask

    task automatic run(input string name, input logic [5:0] c, input logic [31:0] a,
                       input bit good, input int n, input logic [39:0] b);
        got.delete();
        issue(c, a, good);
        wait_idle();
        expect_resp(name, n, b);
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clock);
        #2;
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'hFF);
        chk("rst_card_idle", 32'(card_idle), 32'd1);
        chk("rst_app_pending", 32'(app_pending), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(posedge clock); #1;
        reset = 1'b1;

        rmode = 0;
        run("cmd0", 6'd0, 32'd0, 1, 1, 40'h01_00000000);
        chk("cmd0_latency", 32'(first_v_cyc - trig_cyc), 32'd2);
        chk("cmd0_card_idle", 32'(card_idle), 32'd1);

        run("cmd8", 6'd8, 32'h0000_01AA, 1, 5, 40'h01_00_00_01_AA);
        rmode = 1;
        run("cmd8_toggle", 6'd8, 32'h0000_01AA, 1, 5, 40'h01_00_00_01_AA);
        rmode = 0;

        run("cmd55_a", 6'd55, 32'd0, 1, 1, 40'h01_00000000);
        run("acmd41_a", 6'd41, 32'h4000_0000, 1, 1, 40'h01_00000000);
        run("cmd55_b", 6'd55, 32'd0, 1, 1, 40'h01_00000000);
        run("acmd41_b", 6'd41, 32'h4000_0000, 1, 1, 40'h00_00000000);
        chk("ready_card_idle", 32'(card_idle), 32'd0);
        run("cmd58", 6'd58, 32'd0, 1, 5, 40'h00_C0_FF_80_00);

        run("cmd0_again", 6'd0, 32'd0, 1, 1, 40'h01_00000000);
        run("cmd41_noapp", 6'd41, 32'd0, 1, 1, 40'h05_00000000);
        run("cmd55_c", 6'd55, 32'd0, 1, 1, 40'h01_00000000);
        chk("app_set", 32'(app_pending), 32'd1);
        run("cmd16_512", 6'd16, 32'd512, 1, 1, 40'h01_00000000);
        chk("app_cleared", 32'(app_pending), 32'd0);
        run("cmd16_1218", 6'd16, 32'd1218, 1, 1, 40'h41_00000000);
        run("badcrc", 6'd50, 32'd0, 0, 1, 40'h09_00000000);
        chk("badcrc_idle", 32'(card_idle), 32'd1);
        run("cmd50", 6'd50, 32'd0, 1, 1, 40'h05_00000000);
        run("cmd8_badvhs", 6'd8, 32'h0000_02AA, 1, 5, 40'h01_00_00_00_AA);

        rmode = 2;
        for (int i = 0; i < 60; i++) begin
            logic [5:0]  c;
            logic [31:0] a;
            int          sel;
            sel = $urandom_range(0, 6);
            case (sel)
                0: c = 6'd0;  1: c = 6'd8;  2: c = 6'd16; 3: c = 6'd41;
                4: c = 6'd55; 5: c = 6'd58; default: c = 6'($urandom);
            endcase
            a = $urandom;
            if (c == 6'd16 && $urandom_range(0, 1) == 1) a = 32'd512;
            if (c == 6'd8) a[11:8] = 4'($urandom_range(0, 2));
            got.delete();
            issue(c, a, $urandom_range(0, 7) != 0);
            wait_idle();
        end

        rmode = 0;
        run("cmd0_pre_abort", 6'd0, 32'd0, 1, 1, 40'h01_00000000);
        rmode = 4; tx_ready = 1'b0;
        got.delete();
        issue(6'd8, 32'h0000_01AA, 1);
        @(posedge clock); #1; tx_ready = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1; tx_ready = 1'b0;
        repeat (2) @(posedge clock);
        issue(6'd0, 32'd0, 1);
        tx_ready = 1'b1;
        wait_idle();
        chk("abort_latency", 32'(first_v_cyc - trig_cyc), 32'd2);
        expect_resp("abort", 3, 40'h01_00_01_00_00);

        rmode = 0;
        run("cmd55_d", 6'd55, 32'd0, 1, 1, 40'h01_00000000);
        run("acmd41_c", 6'd41, 32'd0, 1, 1, 40'h01_00000000);
        run("cmd55_e", 6'd55, 32'd0, 1, 1, 40'h01_00000000);
        run("acmd41_d", 6'd41, 32'd0, 1, 1, 40'h00_00000000);
        rmode = 3;
        issue(6'd58, 32'd0, 1);
        @(posedge clock); #2;
        reset = 1'b0;
        #1;
        chk("midrst_tx_valid", 32'(tx_valid), 32'd0);
        chk("midrst_tx_data", 32'(tx_data), 32'hFF);
        chk("midrst_card_idle", 32'(card_idle), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        model_reset();
        rmode = 0;
        repeat (2) @(posedge clock);
        #1; reset = 1'b1;
        run("post_reset_cmd55", 6'd55, 32'd0, 1, 1, 40'h01_00000000);
        chk("post_reset_app", 32'(app_pending), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
